seq_left_normalizer: RTL and testbench
======================================

# seq_left_normalizer

Sequential left normalizer and shift-code encoder: accepts a 16-bit word, shifts it left one bit per clock until bit 15 is set, then reports the normalized word, the shift amount, and a one-hot shift code. It is the opposite end of the team's conditional right barrel shifter. That shifter takes a one-hot-priority shift vector and a data word and shifts right, filling with zeros. Feeding this block's `code` and `dout` into it reproduces the original `din` for any non-zero input.

## Interface
- No parameters; width is fixed at 16.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: request pulse; sampled only in IDLE.
- `din` input 16: word to normalize; sampled on the edge that accepts `start`.
- `dout` output 16: normalized word, registered.
- `code` output 16: one-hot shift code, registered.
  - For non-zero input, bit k is set when the word was shifted left by k.
  - All zeros for zero input.
- `count` output 4: binary shift amount k (0..15), registered.
- `zero` output 1: input word was 0x0000, registered.
- `busy` output 1: state is not IDLE.
- `done` output 1: high for exactly one cycle while state is DONE; `dout`, `code`, `count` and `zero` are valid then.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, on an edge with `start`=1:
  - Load `din` into the data register and clear `count`.
  - If `din`==0: go to DONE with `zero`=1, `code`=0, `dout`=0.
  - Otherwise clear `zero` and go to SHIFT.
- SHIFT, on each edge:
  - If data bit 15 = 1: go to DONE and set `code` = 1 << `count`; no shift this edge.
  - Else shift the data left by 1 (LSB filled with 0) and increment `count`.
- Bounds: `count` never exceeds 15, because a non-zero word reaches bit 15 within 15 shifts. `count` does not wrap; an implementation may assert on any attempt to increment past 15.
- DONE: `done`=1 for one cycle, then unconditionally go to IDLE. `start` is ignored in DONE.
- `start` in SHIFT or DONE is ignored: no restart and no queuing.
- Result hold: `dout`, `code`, `count` and `zero` keep their values in IDLE until the next accepted `start`. `dout` tracks the shifting register during SHIFT and is valid only when `done`=1.
- Round-trip invariant for non-zero `din`:
  - `dout` >> `count` == `din`.
  - `dout`[15] == 1.
  - `code` == 1 << `count`.
- Reset (`rst`=1 at an edge) takes priority over everything, including mid-SHIFT and DONE. State goes to IDLE and every output clears:
  - `dout`=0, `code`=0, `count`=0, `zero`=0, `busy`=0, `done`=0.
  - An aborted operation produces no `done`.
- `start` together with `rst` on the same edge is dropped.

## Timing
- Edge 0 accepts `start`. For non-zero input with shift k, the shifts happen on edges 1..k and DONE is entered at edge k+1.
- `done` is high in the cycle after edge k+1, so latency is k+2 cycles. Minimum 2 (k=0), maximum 17 (k=15).
- Zero input: DONE is entered at edge 0 and `done` is high in the next cycle; latency 1.
- `busy` rises in the cycle after edge 0 and falls in the cycle after `done`.
- Back-to-back: the earliest next `start` is accepted on the edge where the state returns to IDLE plus one, i.e. when `busy`=0 is observed. Throughput is one word per k+3 cycles.
- No combinational path from inputs to outputs.

## Test plan
- `din`=0x8000 -> `done` at latency 2, `dout`=0x8000, `count`=0, `code`=0x0001, `zero`=0.
- `din`=0x0001 -> `done` at latency 17, `dout`=0x8000, `count`=15, `code`=0x8000.
- `din`=0x00F0 -> latency 10, `dout`=0xF000, `count`=8, `code`=0x0100; the right shifter with N=0x0100, D=0xF000 returns 0x00F0.
- `din`=0x0000 -> latency 1, `zero`=1, `dout`=0, `code`=0, `count`=0.
- `din`=0x0003, `start` re-pulsed with `din`=0x1234 during SHIFT -> second `start` ignored; result `dout`=0xC000, `count`=14.
- `din`=0x0010, `rst` asserted after 2 shifts -> all outputs 0 next cycle, no `done` pulse. A new `start` with `din`=0x4000 then yields `dout`=0x8000, `count`=1, `code`=0x0002.
- Random non-zero `din` (≥1000 words): round-trip invariant holds and latency == `count`+2.

Source files
------------

// File: rtl/seq_left_normalizer_if.sv
// Request/result bundle for the sequential left normalizer.
// The master side issues start/din and observes the registered results;
// the slave side (the normalizer) consumes the request and drives the results.
interface seq_left_normalizer_if;
  logic        start;
  logic [15:0] din;
  logic [15:0] dout;
  logic [15:0] code;
  logic [3:0]  count;
  logic        zero;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output din,
    input  dout,
    input  code,
    input  count,
    input  zero,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  din,
    output dout,
    output code,
    output count,
    output zero,
    output busy,
    output done
  );
endinterface

// File: rtl/seq_left_normalizer.sv
// Sequential left normalizer and shift-code encoder.
// Shifts a 16-bit word left one bit per clock until bit 15 is set, then
// reports the normalized word, the binary shift amount and a one-hot code
// (bit k set for a shift of k). code/dout feed the conditional right barrel
// shifter to recover the original word. Zero input finishes at once with
// zero=1 and all-zero results.
module seq_left_normalizer (
  input logic                  clk,
  input logic                  rst,
  seq_left_normalizer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] data;
  logic [15:0] data_nx;
  logic [15:0] code_q;
  logic [15:0] code_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic        zero_q;
  logic        zero_nx;

  // State and result registers; reset clears everything and drops any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data   <= '0;
      code_q <= '0;
      cnt    <= '0;
      zero_q <= 1'b0;
    end else begin
      state  <= state_nx;
      data   <= data_nx;
      code_q <= code_nx;
      cnt    <= cnt_nx;
      zero_q <= zero_nx;
    end
  end

  // Next-state and datapath update; registers hold unless the state acts.
  always_comb begin
    state_nx = state;
    data_nx  = data;
    code_nx  = code_q;
    cnt_nx   = cnt;
    zero_nx  = zero_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          data_nx = bus.din;
          cnt_nx  = '0;
          if (bus.din == '0) begin
            zero_nx  = 1'b1;
            code_nx  = '0;
            state_nx = DONE;
          end else begin
            zero_nx  = 1'b0;
            state_nx = SHIFT;
          end
        end
      end
      SHIFT: begin
        // Test before shifting so an already-normalized word costs no shift.
        if (data[15]) begin
          code_nx  = 16'd1 << cnt;
          state_nx = DONE;
        end else begin
          data_nx = {data[14:0], 1'b0};
          cnt_nx  = cnt + 4'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.dout  = data;
  assign bus.code  = code_q;
  assign bus.count = cnt;
  assign bus.zero  = zero_q;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);

  // A non-zero word reaches bit 15 within 15 shifts, so the counter never wraps.
  a_no_count_wrap : assert property (
    @(posedge clk) disable iff (rst)
      (state == SHIFT && !data[15]) |-> (cnt != 4'd15)
  );

  // Non-zero results are normalized and carry a matching one-hot code.
  a_done_normalized : assert property (
    @(posedge clk) disable iff (rst)
      (state == DONE && !zero_q) |-> (data[15] && code_q == (16'd1 << cnt))
  );

  // Zero results are all-zero.
  a_done_zero : assert property (
    @(posedge clk) disable iff (rst)
      (state == DONE && zero_q) |-> (data == '0 && code_q == '0 && cnt == '0)
  );

endmodule

// File: tb/tb_seq_left_normalizer.sv
// Bench for seq_left_normalizer: directed vector table, hand-written
// multi-cycle sequences (re-pulsed start, mid-shift reset, start with reset),
// and random words checked against a leading-one reference model.
module tb_seq_left_normalizer;

  logic clk;
  logic rst;

  seq_left_normalizer_if bus ();

  seq_left_normalizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass;
  int unsigned n_total;

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_dout;
    logic [15:0] exp_code;
    logic [3:0]  exp_count;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Called just after a posedge: present the request for one edge.
  task automatic start_op(input logic [15:0] w);
    bus.start = 1'b1;
    bus.din   = w;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Sample one cycle at a time until done, with a cycle budget.
  task automatic wait_done(input int lat0, output int lat, output bit ok);
    lat = lat0;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    ok = bus.done;
  endtask

  // Reference: position of the leading one decides the shift.
  function automatic int ref_shift(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      if (w[i]) return 15 - i;
    end
    return 0;
  endfunction

  task automatic run_and_check(input string tag, input logic [15:0] w,
                               input logic [15:0] e_dout, input logic [15:0] e_code,
                               input logic [3:0] e_cnt, input logic e_zero, input int e_lat);
    int lat;
    bit ok;
    logic [15:0] held;
    start_op(w);
    wait_done(1, lat, ok);
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
    chk({tag, "_dout"}, 32'(bus.dout), 32'(e_dout));
    chk({tag, "_code"}, 32'(bus.code), 32'(e_code));
    chk({tag, "_count"}, 32'(bus.count), 32'(e_cnt));
    chk({tag, "_zero"}, 32'(bus.zero), 32'(e_zero));
    held = bus.dout;
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    chk({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    chk({tag, "_dout_hold"}, 32'(bus.dout), 32'(held));
  endtask

  initial begin
    int lat;
    bit ok;
    int k;
    int dones;
    logic [15:0] w;
    logic [15:0] e_dout;

    n_pass  = 0;
    n_total = 0;

    vecs[0] = '{16'h8000, 16'h8000, 16'h0001, 4'd0,  1'b0, 2};
    vecs[1] = '{16'h0001, 16'h8000, 16'h8000, 4'd15, 1'b0, 17};
    vecs[2] = '{16'h00F0, 16'hF000, 16'h0100, 4'd8,  1'b0, 10};
    vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 4'd0,  1'b1, 1};
    vecs[4] = '{16'h4000, 16'h8000, 16'h0002, 4'd1,  1'b0, 3};
    vecs[5] = '{16'h0123, 16'h9180, 16'h0080, 4'd7,  1'b0, 9};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.din   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout", 32'(bus.dout), 32'd0);
    chk("reset_code", 32'(bus.code), 32'd0);
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_zero", 32'(bus.zero), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp_dout,
                    vecs[i].exp_code, vecs[i].exp_count, vecs[i].exp_zero, vecs[i].exp_lat);
    end

    // Second start during SHIFT must be ignored.
    start_op(16'h0003);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.din   = 16'h1234;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("repulse_busy", 32'(bus.busy), 32'd1);
    wait_done(3, lat, ok);
    chk("repulse_done_seen", 32'(ok), 32'd1);
    chk("repulse_latency", 32'(lat), 32'd16);
    chk("repulse_dout", 32'(bus.dout), 32'hC000);
    chk("repulse_count", 32'(bus.count), 32'd14);
    chk("repulse_code", 32'(bus.code), 32'h4000);
    @(posedge clk);
    #1;

    // Reset after two shifts aborts without a done pulse.
    start_op(16'h0010);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("abort_count_mid", 32'(bus.count), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_dout", 32'(bus.dout), 32'd0);
    chk("abort_code", 32'(bus.code), 32'd0);
    chk("abort_count", 32'(bus.count), 32'd0);
    chk("abort_zero", 32'(bus.zero), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    dones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_and_check("after_abort", 16'h4000, 16'h8000, 16'h0002, 4'd1, 1'b0, 3);

    // Start coinciding with reset is dropped.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.din   = 16'h0005;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("start_with_rst_busy", 32'(bus.busy), 32'd0);
    dones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    chk("start_with_rst_no_done", 32'(dones), 32'd0);

    // Random non-zero words, biased across all shift amounts.
    for (int n = 0; n < 1000; n++) begin
      w = 16'($urandom) >> $urandom_range(0, 15);
      if (w == '0) w = 16'h0001;
      k = ref_shift(w);
      e_dout = w << k;
      start_op(w);
      wait_done(1, lat, ok);
      chk("rand_done_seen", 32'(ok), 32'd1);
      chk("rand_latency", 32'(lat), 32'(k + 2));
      chk("rand_dout", 32'(bus.dout), 32'(e_dout));
      chk("rand_count", 32'(bus.count), 32'(k));
      chk("rand_code", 32'(bus.code), 32'(16'd1 << k));
      chk("rand_zero", 32'(bus.zero), 32'd0);
      chk("rand_roundtrip", 32'(bus.dout >> bus.count), 32'(w));
      chk("rand_msb", 32'(bus.dout[15]), 32'd1);
      chk("rand_lat_vs_count", 32'(lat), 32'(bus.count) + 32'd2);
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
